countdown_timer: RTL and testbench
==================================

# countdown_timer

Down-counting tick consumer for the game timing chain. An up-counter produces one-cycle `hitTop` strobes at a fixed rate; this block takes those strobes as `i_tick`, counts a loaded value down to zero, and reports expiry with a one-cycle `o_done` pulse. Game control uses it for dealer pacing, card-reveal delays and turn time-outs. It also provides start, hold and restart control, and a busy flag for the FSM that issues them.

## Interface
- `WIDTH`, 16: width of the loaded value and of `o_remaining`.
- `DECREMENT`, 1: amount subtracted per accepted tick. Must be nonzero and less than 2^WIDTH.
- `i_clk` input 1: clock. All logic is rising-edge.
- `i_reset` input 1: reset, asynchronous, active-high.
- `i_start` input 1: one-cycle request to load `i_load` and begin counting. Honoured in every state.
- `i_load` input WIDTH: start value, sampled only when `i_start` is high.
- `i_tick` input 1: rate strobe, one `i_clk` cycle wide. It comes from an up-counter's `hitTop` output.
- `i_hold` input 1: level signal. While high, counting is frozen.
- `o_busy` output 1: high in RUN or HOLD.
- `o_done` output 1: registered, one-cycle expiry pulse.
- `o_remaining` output WIDTH: current count, registered.
- `o_state` output 2: state encoding. IDLE=00, RUN=01, HOLD=10, DONE=11.

## Operation
- **Reset.** While `i_reset` is high, and asynchronously:
  - state goes to IDLE;
  - `o_remaining` goes to 0;
  - `o_done` and `o_busy` go to 0;
  - the reload register goes to 0.
- **Reset mid-count.** The count is abandoned. No `o_done` pulse is emitted.
- **Priority within a cycle.** `i_start` > `i_hold` > `i_tick`.
- **`i_start` (any state):**
  - `o_remaining` <= `i_load`, and the reload register <= `i_load`.
  - Next state is RUN if `i_load` != 0.
  - If `i_load` == 0, next state is DONE and `o_done` pulses in that same next cycle.
  - A tick or hold in the start cycle is ignored.
  - Restarting while in RUN or HOLD discards the old count with no `o_done`.
- **IDLE:** waits for `i_start`. Ticks and hold are ignored.
- **RUN:**
  - `i_hold` high: go to HOLD. A coincident tick is dropped.
  - Else, on `i_tick`, if `o_remaining` > `DECREMENT`: subtract `DECREMENT`.
  - Else, on `i_tick` (`o_remaining` <= `DECREMENT`): set `o_remaining` to 0, go to DONE, pulse `o_done`.
- **HOLD:** ticks are ignored and `o_remaining` is frozen. When `i_hold` is low, go to RUN. The first tick is accepted in the cycle after the return to RUN.
- **DONE:** `o_remaining` stays at 0 and `o_done` is low after its single pulse. Only `i_start` or reset leaves this state.
- **Arithmetic:** saturating at 0, so no wrap-around. The compare and subtract are WIDTH bits, unsigned.
- **Consecutive ticks:** back-to-back ticks on consecutive cycles are all honoured.

## Timing
- Start to RUN latency is 1 cycle. `o_busy` and `o_remaining` are valid in the cycle after `i_start`.
- Tick to `o_remaining` update is 1 cycle.
- The expiring tick at edge N produces `o_done`=1 and `o_state`=DONE for exactly cycle N+1.
- With `DECREMENT`=1 and load L, `o_done` follows the L-th accepted tick by 1 cycle.
- `i_start` has no handshake. It is accepted every cycle it is high. Held high, it reloads continuously and never expires.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `COUNTDOWN_TIMER_AUTORELOAD_EN`.
- **Defined:**
  - An expiring tick in RUN pulses `o_done`, loads `o_remaining` from the reload register, and stays in RUN. This gives a periodic pulse every reload-value/`DECREMENT` accepted ticks (rounded up), with `o_busy` held high.
  - A load of 0 still goes to DONE, with no reload.
  - Hold and restart behave as described above.
- **Undefined:** the reload register is omitted and expiry always goes to DONE.

## Test plan
- **Basic count.** Reset, then `i_start` with `i_load`=3 and ticks every 4 cycles.
  - `o_remaining` goes 3, 2, 1, 0.
  - `o_done` is high for exactly one cycle, 1 cycle after the 3rd tick. The state is then DONE and `o_busy` is 0.
- **Zero load.** `i_start` with `i_load`=0: next cycle shows `o_state`=DONE and a one-cycle `o_done`, with `o_busy` never high.
- **Hold.** Load 5, accept 2 ticks, raise `i_hold` for 10 cycles with 3 ticks during it, then drop it.
  - `o_remaining` stays 3 throughout.
  - A tick coincident with the hold rise is dropped.
  - 3 more ticks then give `o_done`.
- **Restart and reset.** Load 10, tick twice, then `i_start` with `i_load`=2 to get `o_remaining`=2 with no `o_done`. Assert `i_reset` mid-count to get the IDLE state with 0 on all outputs.
- **Saturation.** `DECREMENT`=4, load 6, back-to-back ticks give 6, 2, 0, then `o_done`. There is no wrap to a large value.
- **Autoreload (macro defined).** Load 2 and tick every cycle.
  - `o_done` pulses on every 2nd tick.
  - `o_remaining` goes 2, 1, 2, 1, …
  - `o_busy` stays 1.

Source files
------------

// File: rtl/countdown_timer.sv
// Down-counting tick consumer: loads a start value, decrements on accepted ticks, pulses o_done on expiry.
// Optional periodic mode via COUNTDOWN_TIMER_AUTORELOAD_EN (reload from the last loaded value on expiry).
module countdown_timer #(
  parameter int WIDTH     = 16,
  parameter int DECREMENT = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_load,
  input  logic             i_tick,
  input  logic             i_hold,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_remaining,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0] DEC = WIDTH'(DECREMENT);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] remaining, remaining_nxt;
  logic             done_nxt;
  logic             busy_nxt;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload, reload_nxt;
`endif

  // Callers only use this when a > DEC, but it floors at zero regardless.
  function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] a);
    sat_sub = (a > DEC) ? (a - DEC) : '0;
  endfunction

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    done_nxt      = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    reload_nxt    = reload;
`endif
    if (i_start) begin
      remaining_nxt = i_load;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      reload_nxt    = i_load;
`endif
      if (i_load != '0) begin
        state_nxt = RUN;
      end else begin
        state_nxt = DONE;
        done_nxt  = 1'b1;
      end
    end else begin
      unique case (state)
        RUN: begin
          if (i_hold) begin
            state_nxt = HOLD;
          end else if (i_tick) begin
            if (remaining > DEC) begin
              remaining_nxt = sat_sub(remaining);
            end else begin
              done_nxt = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
              remaining_nxt = reload;
`else
              remaining_nxt = '0;
              state_nxt     = DONE;
`endif
            end
          end
        end
        HOLD: begin
          if (!i_hold) state_nxt = RUN;
        end
        DONE: begin
          remaining_nxt = '0;
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
    busy_nxt = (state_nxt == RUN) || (state_nxt == HOLD);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      remaining <= '0;
      o_done    <= 1'b0;
      o_busy    <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      reload    <= '0;
`endif
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      o_done    <= done_nxt;
      o_busy    <= busy_nxt;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      reload    <= reload_nxt;
`endif
    end
  end

  assign o_remaining = remaining;
  assign o_state     = state;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: two timers (decrement 1 and 4) on shared stimulus, compared every cycle
// against a behavioural model; directed test-plan sequences followed by random traffic.
module tb_countdown_timer;

  logic        i_clk;
  logic        i_reset;
  logic        i_start;
  logic [15:0] i_load;
  logic        i_tick;
  logic        i_hold;

  logic        busy1, done1, busy4, done4;
  logic [15:0] rem1, rem4;
  logic [1:0]  st1, st4;

  int checks   = 0;
  int failures = 0;

  countdown_timer #(.WIDTH(16), .DECREMENT(1)) dut1 (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_load(i_load),
    .i_tick(i_tick), .i_hold(i_hold), .o_busy(busy1), .o_done(done1),
    .o_remaining(rem1), .o_state(st1)
  );

  countdown_timer #(.WIDTH(16), .DECREMENT(4)) dut4 (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_load(i_load),
    .i_tick(i_tick), .i_hold(i_hold), .o_busy(busy4), .o_done(done4),
    .o_remaining(rem4), .o_state(st4)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Model: the timer is either idle, counting, frozen or finished.
  typedef struct {
    int rem;
    int reload;
    bit counting;
    bit frozen;
    bit finished;
    bit pulse;
  } model_t;

  model_t m1, m4;

  function automatic model_t model_reset();
    model_t m;
    m.rem = 0; m.reload = 0; m.counting = 0; m.frozen = 0; m.finished = 0; m.pulse = 0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, int dec, bit s, int ld, bit t, bit h);
    model_t n = m;
    n.pulse = 0;
    if (s) begin
      n.rem = ld; n.reload = ld; n.frozen = 0;
      n.counting = (ld != 0);
      n.finished = (ld == 0);
      n.pulse    = (ld == 0);
    end else if (m.counting) begin
      if (h) begin
        n.counting = 0; n.frozen = 1;
      end else if (t) begin
        if (m.rem - dec > 0) n.rem = m.rem - dec;
        else begin
          n.pulse = 1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
          n.rem = m.reload;
`else
          n.rem = 0; n.counting = 0; n.finished = 1;
`endif
        end
      end
    end else if (m.frozen) begin
      if (!h) begin
        n.frozen = 0; n.counting = 1;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
      $error("check %s", tag);
    end
  endtask

  task automatic compare_all();
    logic [1:0] e1, e4;
    e1 = m1.finished ? 2'b11 : m1.frozen ? 2'b10 : m1.counting ? 2'b01 : 2'b00;
    e4 = m4.finished ? 2'b11 : m4.frozen ? 2'b10 : m4.counting ? 2'b01 : 2'b00;
    check("d1_state", 32'(st1), 32'(e1));
    check("d1_rem",   32'(rem1), 32'(m1.rem));
    check("d1_done",  32'(done1), 32'(m1.pulse));
    check("d1_busy",  32'(busy1), 32'(m1.counting | m1.frozen));
    check("d4_state", 32'(st4), 32'(e4));
    check("d4_rem",   32'(rem4), 32'(m4.rem));
    check("d4_done",  32'(done4), 32'(m4.pulse));
    check("d4_busy",  32'(busy4), 32'(m4.counting | m4.frozen));
  endtask

  // Called 1 time unit after a rising edge; drives, clocks, then checks.
  task automatic cyc(input bit s, input int ld, input bit t, input bit h);
    i_start = s; i_load = 16'(ld); i_tick = t; i_hold = h;
    @(posedge i_clk);
    m1 = model_step(m1, 1, s, ld, t, h);
    m4 = model_step(m4, 4, s, ld, t, h);
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    i_start = 0; i_tick = 0; i_hold = 0;
    #2 i_reset = 1'b1;
    #1;
    m1 = model_reset();
    m4 = model_reset();
    compare_all();
    check("rst_state_zero", 32'(st1), 32'd0);
    @(posedge i_clk);
    #1 i_reset = 1'b0;
    compare_all();
  endtask

  initial begin
    i_reset = 1'b1; i_start = 0; i_load = 0; i_tick = 0; i_hold = 0;
    m1 = model_reset();
    m4 = model_reset();
    #3;
    compare_all();
    @(posedge i_clk);
    #1 i_reset = 1'b0;

    // Basic count: load 3, a tick every 4 cycles.
    cyc(1, 3, 0, 0);
    check("basic_rem_load", 32'(rem1), 32'd3);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 0);
    end
    check("basic_done_pulse", 32'(done1), 32'd1);
    cyc(0, 0, 0, 0);
    check("basic_done_single", 32'(done1), 32'd0);

    // Zero load goes straight to DONE with one pulse.
    cyc(1, 0, 1, 1);
    check("zero_state", 32'(st1), 32'd3);
    check("zero_done", 32'(done1), 32'd1);
    cyc(0, 0, 1, 0);

    // Hold: load 5, two ticks, hold for 10 cycles with ticks, release, three ticks.
    cyc(1, 5, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    for (int j = 0; j < 10; j++) cyc(0, 0, (j == 0 || j == 4 || j == 8), 1);
    check("hold_frozen", 32'(rem1), 32'd3);
    cyc(0, 0, 1, 0);
    for (int j = 0; j < 3; j++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);

    // Restart mid-count, then asynchronous reset mid-count.
    cyc(1, 10, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 2, 1, 0);
    check("restart_rem", 32'(rem1), 32'd2);
    cyc(0, 0, 1, 0);
    async_reset();

    // Saturation on the decrement-4 timer: 6, 2, 0.
    cyc(1, 6, 0, 0);
    cyc(0, 0, 1, 0);
    check("sat_rem2", 32'(rem4), 32'd2);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);

    // Autoreload-style periodic run (one-shot in the default build).
    cyc(1, 2, 0, 0);
    for (int j = 0; j < 8; j++) cyc(0, 0, 1, 0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(199) == 0) async_reset();
      else cyc($urandom_range(29) == 0,
               ($urandom_range(7) == 0) ? 0 : int'($urandom_range(24)),
               $urandom_range(1) == 1,
               $urandom_range(9) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
